// File: rtl/irq_priority_encoder_pkg.sv
// Shared constants and FSM state encoding for the 8-line interrupt priority encoder.
package irq_priority_encoder_pkg;

    localparam int N_IRQ       = 8;
    localparam int ID_W        = 3;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder_sync.sv
// Vector synchronizer for asynchronous active-low request lines; resets to all ones (idle).
module irq_priority_encoder_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/irq_priority_encoder.sv
// Edge-latching interrupt encoder: synchronizes active-low requests, keeps pending bits and
// presents the lowest-index eligible line to the CPU through a req/ack/eoi handshake.
module irq_priority_encoder
    import irq_priority_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_IRQ-1:0] irq_n,
    input  logic [N_IRQ-1:0] mask,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_IRQ-1:0] pending,
    output logic             busy
);

    logic [N_IRQ-1:0] sync_irq_n;
    logic [N_IRQ-1:0] prev_irq_n;
    logic [N_IRQ-1:0] fell;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pending_d;
    logic [ID_W-1:0]  id_d;
    irq_state_e       state_q;
    irq_state_e       state_d;

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_IRQ-1:0] v);
        lowest_set = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = ID_W'(i);
        end
    endfunction

    irq_priority_encoder_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_n),
        .q     (sync_irq_n)
    );

    assign fell     = prev_irq_n & ~sync_irq_n;
    assign eligible = pending & ~mask;

    always_comb begin
        state_d = state_q;
        id_d    = int_id;
        clr     = '0;
        if (!ena) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (eligible != '0) begin
                        state_d = S_REQ;
                        id_d    = lowest_set(eligible);
                    end
                end
                S_REQ: begin
                    // Ack beats a simultaneous mask; a presented id is never pre-empted.
                    if (int_ack) begin
                        state_d     = S_SERVICE;
                        clr[int_id] = 1'b1;
                    end else if (mask[int_id]) begin
                        state_d = S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (int_eoi) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // A fresh edge on the line being acked must survive, so set is applied after clear.
        pending_d = ena ? ((pending & ~clr) | fell) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_irq_n <= '1;
            pending    <= '0;
            state_q    <= S_IDLE;
            int_id     <= '0;
            int_req    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            prev_irq_n <= sync_irq_n;
            pending    <= pending_d;
            state_q    <= state_d;
            int_id     <= id_d;
            int_req    <= (state_d == S_REQ);
            busy       <= (state_d == S_SERVICE);
        end
    end

endmodule
